// File: rtl/fifo_read_ctrl_if.sv
// Read-side bus of the async FIFO: RAM read port towards the dual-clock RAM plus
// the valid/ready output stream towards the consumer.
interface fifo_read_ctrl_if #(
    parameter int unsigned FIFO_WIDTH     = 8,
    parameter int unsigned FIFO_DEPTH_BIT = 4
);
    logic                      r_en;
    logic [FIFO_DEPTH_BIT-1:0] read_addr;
    logic [FIFO_WIDTH-1:0]     data_read;
    logic [FIFO_WIDTH-1:0]     dout;
    logic                      dout_valid;
    logic                      dout_ready;

    modport master (
        output r_en,
        output read_addr,
        input  data_read,
        output dout,
        output dout_valid,
        input  dout_ready
    );

    modport slave (
        input  r_en,
        input  read_addr,
        output data_read,
        input  dout,
        input  dout_valid,
        output dout_ready
    );
endinterface

// File: rtl/fifo_read_ctrl.sv
// Async FIFO read-domain controller: syncs the Gray write pointer, owns the read
// pointer, issues RAM reads and presents words through a 2-entry output buffer.
module fifo_read_ctrl #(
    parameter int unsigned FIFO_WIDTH     = 8,
    parameter int unsigned FIFO_DEPTH     = 16,
    parameter int unsigned FIFO_DEPTH_BIT = 4
) (
    input  logic                    r_clk,
    input  logic                    r_rst_n,
    input  logic [FIFO_DEPTH_BIT:0] w_ptr_gray,
    output logic [FIFO_DEPTH_BIT:0] r_ptr_gray,
    output logic                    flag_empty,
    output logic [FIFO_DEPTH_BIT:0] level,
    fifo_read_ctrl_if.master        bus
);

    localparam int unsigned PTR_W = FIFO_DEPTH_BIT + 1;

    if (FIFO_DEPTH != (32'd1 << FIFO_DEPTH_BIT)) begin : g_depth_check
        $error("FIFO_DEPTH must equal 2**FIFO_DEPTH_BIT");
    end

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_e;

    logic [PTR_W-1:0]      wq1_q;
    logic [PTR_W-1:0]      wq2_q;
    logic [PTR_W-1:0]      wq2_bin;
    logic [PTR_W-1:0]      r_ptr_bin_q;
    logic [PTR_W-1:0]      r_ptr_bin_d;
    logic [PTR_W-1:0]      r_ptr_gray_q;
    logic [PTR_W-1:0]      r_ptr_gray_d;
    logic                  inflight_q;
    logic                  inflight_d;
    buf_state_e            buf_state_q;
    logic [FIFO_WIDTH-1:0] dout_q;
    logic [FIFO_WIDTH-1:0] skid_q;
    logic [2:0]            occupancy;
    logic                  pop;
    logic                  rd_issue;

    always_comb begin
        wq2_bin = '0;
        for (int unsigned i = 0; i < PTR_W; i++) begin
            wq2_bin[i] = ^(wq2_q >> i);
        end
    end

    assign flag_empty = (r_ptr_gray_q == wq2_q);
    assign level      = wq2_bin - r_ptr_bin_q;
    assign r_ptr_gray = r_ptr_gray_q;

    assign pop       = (buf_state_q != BUF_EMPTY) && bus.dout_ready;
    assign occupancy = 3'(buf_state_q) + 3'(inflight_q);

    // A pop this cycle frees a slot for the word issued now, which is what keeps
    // a steady stream at one word per cycle with only two buffer entries.
    assign rd_issue = !flag_empty &&
                      ((occupancy < 3'd2) || ((occupancy == 3'd2) && pop));

    always_comb begin
        r_ptr_bin_d  = r_ptr_bin_q + PTR_W'(rd_issue);
        r_ptr_gray_d = r_ptr_bin_d ^ (r_ptr_bin_d >> 1);
        inflight_d   = rd_issue;
    end

    always_ff @(posedge r_clk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            wq1_q        <= '0;
            wq2_q        <= '0;
            r_ptr_bin_q  <= '0;
            r_ptr_gray_q <= '0;
            inflight_q   <= 1'b0;
        end else begin
            wq1_q        <= w_ptr_gray;
            wq2_q        <= wq1_q;
            r_ptr_bin_q  <= r_ptr_bin_d;
            r_ptr_gray_q <= r_ptr_gray_d;
            inflight_q   <= inflight_d;
        end
    end

    // Output buffer: dout_q is the head, skid_q the second entry. A capture that
    // coincides with a pop fills the slot the pop frees, keeping order.
    always_ff @(posedge r_clk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            buf_state_q <= BUF_EMPTY;
            dout_q      <= '0;
            skid_q      <= '0;
        end else begin
            case (buf_state_q)
                BUF_EMPTY: begin
                    if (inflight_q) begin
                        dout_q      <= bus.data_read;
                        buf_state_q <= BUF_ONE;
                    end
                end
                BUF_ONE: begin
                    if (inflight_q) begin
                        if (pop) begin
                            dout_q <= bus.data_read;
                        end else begin
                            skid_q      <= bus.data_read;
                            buf_state_q <= BUF_TWO;
                        end
                    end else if (pop) begin
                        buf_state_q <= BUF_EMPTY;
                    end
                end
                BUF_TWO: begin
                    if (pop) begin
                        dout_q <= skid_q;
                        if (inflight_q) begin
                            skid_q <= bus.data_read;
                        end else begin
                            buf_state_q <= BUF_ONE;
                        end
                    end
                end
                default: begin
                    buf_state_q <= BUF_EMPTY;
                end
            endcase
        end
    end

    assign bus.r_en       = rd_issue;
    assign bus.read_addr  = r_ptr_bin_q[FIFO_DEPTH_BIT-1:0];
    assign bus.dout       = dout_q;
    assign bus.dout_valid = (buf_state_q != BUF_EMPTY);

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Directed bench for fifo_read_ctrl: a RAM model, a write-pointer driver and a
// scoreboard of expected words compared as the consumer pops them.
module tb_fifo_read_ctrl;

    logic       r_clk = 1'b0;
    logic       r_rst_n = 1'b0;
    logic [4:0] w_ptr_gray = '0;
    logic [4:0] r_ptr_gray;
    logic       flag_empty;
    logic [4:0] level;

    logic [7:0] mem [16];
    logic [7:0] sb [$];
    logic [4:0] wbin = '0;
    int         checks = 0;
    int         failures = 0;

    fifo_read_ctrl_if #(.FIFO_WIDTH(8), .FIFO_DEPTH_BIT(4)) bus ();

    fifo_read_ctrl #(
        .FIFO_WIDTH    (8),
        .FIFO_DEPTH    (16),
        .FIFO_DEPTH_BIT(4)
    ) dut (
        .r_clk     (r_clk),
        .r_rst_n   (r_rst_n),
        .w_ptr_gray(w_ptr_gray),
        .r_ptr_gray(r_ptr_gray),
        .flag_empty(flag_empty),
        .level     (level),
        .bus       (bus)
    );

    always #5 r_clk = ~r_clk;

    // Synchronous-read RAM: data appears the cycle after r_en is sampled.
    always @(posedge r_clk) begin
        if (bus.r_en) bus.data_read <= mem[bus.read_addr];
    end

    function automatic logic [4:0] gray(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // A pop happens at the next rising edge whenever valid and ready are both high.
    always @(negedge r_clk) begin
        if (r_rst_n && bus.dout_valid && bus.dout_ready) begin
            check("sb_nonempty", (sb.size() != 0) ? 32'd1 : 32'd0, 32'd1);
            if (sb.size() != 0) check("sb_data", 32'(bus.dout), 32'(sb.pop_front()));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge r_clk);
        #1;
    endtask

    task automatic push_words(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            logic [7:0] v;
            v = 8'($urandom_range(0, 255));
            mem[wbin[3:0]] = v;
            sb.push_back(v);
            wbin = wbin + 5'd1;
        end
        w_ptr_gray = gray(wbin);
    endtask

    task automatic drain(input string tag);
        int unsigned n;
        n = 0;
        bus.dout_ready = 1'b1;
        while (!(sb.size() == 0 && !bus.dout_valid) && n < 200) begin
            tick();
            n++;
        end
        check(tag, (n < 200) ? 32'd1 : 32'd0, 32'd1);
        check({tag, "_level"}, 32'(level), 32'd0);
        check({tag, "_empty"}, 32'(flag_empty), 32'd1);
    endtask

    initial begin
        int nre;
        int first;
        int last;
        int k;
        logic [3:0] exp_addr [4];

        for (int i = 0; i < 16; i++) mem[i] = '0;
        bus.dout_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge r_clk);
        #1;
        check("rst_r_en", 32'(bus.r_en), 32'd0);
        check("rst_empty", 32'(flag_empty), 32'd1);
        check("rst_valid", 32'(bus.dout_valid), 32'd0);
        check("rst_rgray", 32'(r_ptr_gray), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_dout", 32'(bus.dout), 32'd0);
        r_rst_n = 1'b1;
        tick();

        // Single word: latency and address
        mem[0] = 8'hA5;
        sb.push_back(8'hA5);
        wbin = 5'd1;
        w_ptr_gray = gray(wbin);
        tick();
        check("t2_e0_r_en", 32'(bus.r_en), 32'd0);
        tick();
        check("t2_e1_r_en", 32'(bus.r_en), 32'd1);
        check("t2_e1_addr", 32'(bus.read_addr), 32'd0);
        check("t2_e1_level", 32'(level), 32'd1);
        check("t2_e1_empty", 32'(flag_empty), 32'd0);
        tick();
        check("t2_e2_r_en", 32'(bus.r_en), 32'd0);
        check("t2_e2_level", 32'(level), 32'd0);
        check("t2_e2_empty", 32'(flag_empty), 32'd1);
        check("t2_e2_valid", 32'(bus.dout_valid), 32'd0);
        tick();
        check("t2_e3_valid", 32'(bus.dout_valid), 32'd1);
        check("t2_e3_dout", 32'(bus.dout), 32'hA5);
        drain("t2_drain");

        // Sixteen words with ready held: continuous issue
        bus.dout_ready = 1'b1;
        push_words(16);
        tick();
        tick();
        check("t3_level16", 32'(level), 32'd16);
        nre = 0;
        first = -1;
        last = -1;
        for (int i = 0; i < 60 && nre < 16; i++) begin
            if (bus.r_en) begin
                nre++;
                if (first < 0) first = i;
                last = i;
            end
            if (nre < 16) tick();
        end
        tick();
        check("t3_nre", 32'(nre), 32'd16);
        check("t3_span", 32'(last - first + 1), 32'd16);
        check("t3_empty", 32'(flag_empty), 32'd1);
        check("t3_r_en_off", 32'(bus.r_en), 32'd0);
        drain("t3_drain");

        // Backpressure: only two reads outstanding, head word held
        bus.dout_ready = 1'b0;
        push_words(5);
        nre = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.r_en) nre++;
        end
        check("t4_nre", 32'(nre), 32'd2);
        check("t4_level", 32'(level), 32'd3);
        check("t4_valid", 32'(bus.dout_valid), 32'd1);
        check("t4_dout", 32'(bus.dout), 32'(sb[0]));
        repeat (3) tick();
        check("t4_dout_hold", 32'(bus.dout), 32'(sb[0]));
        check("t4_valid_hold", 32'(bus.dout_valid), 32'd1);
        drain("t4_drain");

        // Multi-count jump of the write pointer
        bus.dout_ready = 1'b0;
        push_words(7);
        tick();
        tick();
        check("t6_level7", 32'(level), 32'd7);
        check("t6_empty", 32'(flag_empty), 32'd0);
        drain("t6_drain");

        // Wrap through pointer value 31 -> 0
        push_words(1);
        drain("t5_pre_drain");
        check("t5_rgray30", 32'(r_ptr_gray), 32'(5'b10001));
        exp_addr[0] = 4'd14;
        exp_addr[1] = 4'd15;
        exp_addr[2] = 4'd0;
        exp_addr[3] = 4'd1;
        bus.dout_ready = 1'b1;
        push_words(4);
        k = 0;
        for (int i = 0; i < 30 && k < 4; i++) begin
            tick();
            if (bus.r_en) begin
                check("t5_addr", 32'(bus.read_addr), 32'(exp_addr[k]));
                k++;
            end
        end
        check("t5_nreads", 32'(k), 32'd4);
        drain("t5_drain");
        check("t5_rgray_end", 32'(r_ptr_gray), 32'(5'b00011));

        // Reset while words are buffered and in flight
        bus.dout_ready = 1'b0;
        push_words(5);
        repeat (4) tick();
        r_rst_n = 1'b0;
        #1;
        check("t1_r_en", 32'(bus.r_en), 32'd0);
        check("t1_empty", 32'(flag_empty), 32'd1);
        check("t1_valid", 32'(bus.dout_valid), 32'd0);
        check("t1_rgray", 32'(r_ptr_gray), 32'd0);
        check("t1_level", 32'(level), 32'd0);
        sb.delete();
        wbin = '0;
        w_ptr_gray = '0;
        tick();
        r_rst_n = 1'b1;
        tick();
        push_words(2);
        drain("t1_recover");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
